// File: rtl/bnn_pkg.sv
// Shared constants and arithmetic helpers for the binarized systolic array.
package bnn_pkg;

    localparam int ACT_BITS   = 9;
    localparam int PSUM_WIDTH = 14;
    localparam int ACC_WIDTH  = 16;

    // Two's complement add that clamps to the most positive / most negative
    // ACC_WIDTH value instead of wrapping.
    function automatic logic signed [ACC_WIDTH-1:0] sat_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [ACC_WIDTH-1:0] b
    );
        logic [ACC_WIDTH:0] s;
        s = {a[ACC_WIDTH-1], a} + {b[ACC_WIDTH-1], b};
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            // Sign of the true result is the extra top bit.
            return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
        return s[ACC_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/act_fifo2.sv
// Two-entry FIFO holding packed activation words on their way to the
// next layer's activation buffer.
module act_fifo2
    import bnn_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push_i,
    input  logic [ACT_BITS-1:0] push_data_i,
    output logic                full_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [ACT_BITS-1:0] data_o
);

    logic [ACT_BITS-1:0] mem_q [2];
    logic                wr_ptr_q;
    logic                rd_ptr_q;
    logic [1:0]          count_q;
    logic                do_push;
    logic                do_pop;

    assign full_o  = (count_q == 2'd2);
    assign valid_o = (count_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full buffer is ignored; the producer never issues one.
    assign do_push = push_i & ~full_o;
    assign do_pop  = valid_o & ready_i;

    // Storage, pointers and occupancy; no bypass, so a word written at an
    // edge is visible on data_o only from the following cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/psum_collector.sv
// Column-end partial-sum collector: accumulates psums over channel-group
// passes, binarizes each finished pixel and packs nine pixels per word.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. On the psum side ready drops only when the output buffer is
// full and a beat offered then is lost (flagged by overflow_out). On the
// activation side valid and data hold steady until the transfer occurs.
module psum_collector
    import bnn_pkg::*;
#(
    parameter int WIDTH     = PSUM_WIDTH,
    parameter int ACC_WIDTH = bnn_pkg::ACC_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 psum_valid_in,
    input  logic [WIDTH-1:0]     psum_in,
    output logic                 psum_ready_out,
    input  logic [3:0]           cfg_passes_in,
    input  logic [ACC_WIDTH-1:0] cfg_threshold_in,
    input  logic                 flush_in,
    output logic                 act_valid_out,
    input  logic                 act_ready_in,
    output logic [ACT_BITS-1:0]  activation_out,
    output logic                 busy_out,
    output logic                 overflow_out
);

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [3:0]                  pass_cnt_q, pass_cnt_d;
    logic [3:0]                  bit_cnt_q, bit_cnt_d;
    logic [ACT_BITS-1:0]         shreg_q, shreg_d;
    logic                        overflow_q;

    logic                        fifo_full;
    logic                        accept;
    logic [3:0]                  last_pass;
    logic                        is_final;
    logic signed [ACC_WIDTH-1:0] psum_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic                        pix_bit;
    logic                        push;
    logic [ACT_BITS-1:0]         push_data;

    assign psum_ready_out = ~fifo_full;
    assign accept         = psum_valid_in & psum_ready_out;
    assign busy_out       = (pass_cnt_q != 4'd0) || (bit_cnt_q != 4'd0);
    assign overflow_out   = overflow_q;

    // A pass count of zero behaves like one pass. Using >= for the final
    // test keeps the counter from running away if passes shrinks mid-pixel.
    assign last_pass = (cfg_passes_in == 4'd0) ? 4'd0 : cfg_passes_in - 4'd1;
    assign is_final  = (pass_cnt_q >= last_pass);
    assign psum_ext  = {{(ACC_WIDTH-WIDTH){psum_in[WIDTH-1]}}, psum_in};
    assign sum       = sat_add(acc_q, psum_ext);
    assign pix_bit   = (sum >= $signed(cfg_threshold_in));

    // Next-state: process an accepted beat first, then apply flush on top.
    always_comb begin
        acc_d      = acc_q;
        pass_cnt_d = pass_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        push       = 1'b0;
        push_data  = '0;

        if (accept) begin
            if (!is_final) begin
                acc_d      = sum;
                pass_cnt_d = pass_cnt_q + 4'd1;
            end else begin
                acc_d      = '0;
                pass_cnt_d = 4'd0;
                if (bit_cnt_q == 4'(ACT_BITS-1)) begin
                    push      = 1'b1;
                    push_data = {pix_bit, shreg_q[ACT_BITS-2:0]};
                    bit_cnt_d = 4'd0;
                    shreg_d   = '0;
                end else begin
                    shreg_d[bit_cnt_q] = pix_bit;
                    bit_cnt_d          = bit_cnt_q + 4'd1;
                end
            end
        end

        if (flush_in && psum_ready_out) begin
            // A word just completed by this cycle's beat leaves bit_cnt_d at
            // zero, so it is never pushed twice.
            if (!push && (bit_cnt_d != 4'd0)) begin
                push      = 1'b1;
                push_data = shreg_d;
            end
            acc_d      = '0;
            pass_cnt_d = 4'd0;
            bit_cnt_d  = 4'd0;
            shreg_d    = '0;
        end
    end

    // Accumulator, counters, packing register and sticky overflow flag.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            acc_q      <= '0;
            pass_cnt_q <= 4'd0;
            bit_cnt_q  <= 4'd0;
            shreg_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            pass_cnt_q <= pass_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            if (psum_valid_in && !psum_ready_out) begin
                overflow_q <= 1'b1;
            end
        end
    end

    act_fifo2 u_fifo (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .push_i      (push),
        .push_data_i (push_data),
        .full_o      (fifo_full),
        .valid_o     (act_valid_out),
        .ready_i     (act_ready_in),
        .data_o      (activation_out)
    );

endmodule

// File: tb/tb_psum_collector.sv
// Directed bench for psum_collector: packing, multi-pass accumulation,
// saturation, backpressure, flush, back-to-back traffic and mid-run reset.
module tb_psum_collector;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        psum_valid_in;
    logic [13:0] psum_in;
    logic        psum_ready_out;
    logic [3:0]  cfg_passes_in;
    logic [15:0] cfg_threshold_in;
    logic        flush_in;
    logic        act_valid_out;
    logic        act_ready_in;
    logic [8:0]  activation_out;
    logic        busy_out;
    logic        overflow_out;

    int checks = 0;
    int errors = 0;

    // Pattern A binarizes (thr 0) to 9'h0B5, pattern B to 9'h15A.
    int pat_a[9] = '{9, -9, 1, -1, 0, 3, -5, 7, -7};
    int pat_b[9] = '{-9, 9, -1, 1, 0, -3, 5, -7, 7};

    psum_collector dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .psum_valid_in    (psum_valid_in),
        .psum_in          (psum_in),
        .psum_ready_out   (psum_ready_out),
        .cfg_passes_in    (cfg_passes_in),
        .cfg_threshold_in (cfg_threshold_in),
        .flush_in         (flush_in),
        .act_valid_out    (act_valid_out),
        .act_ready_in     (act_ready_in),
        .activation_out   (activation_out),
        .busy_out         (busy_out),
        .overflow_out     (overflow_out)
    );

    // Clock and watchdog
    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks: inputs change 1 time unit after a rising edge.
    task automatic send_beat(input int v);
        psum_valid_in = 1'b1;
        psum_in       = 14'(v);
        @(posedge clk_in); #1;
        psum_valid_in = 1'b0;
    endtask

    task automatic send_pattern(input int n, input bit use_b);
        for (int i = 0; i < n; i++) begin
            send_beat(use_b ? pat_b[i] : pat_a[i]);
        end
    endtask

    task automatic send_flush();
        flush_in = 1'b1;
        @(posedge clk_in); #1;
        flush_in = 1'b0;
    endtask

    task automatic pop_word();
        act_ready_in = 1'b1;
        @(posedge clk_in); #1;
        act_ready_in = 1'b0;
    endtask

    task automatic test_reset();
        rst_in = 1'b0; psum_valid_in = 1'b0; psum_in = '0; flush_in = 1'b0;
        act_ready_in = 1'b0; cfg_passes_in = 4'd1; cfg_threshold_in = '0;
        #12;
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", act_valid_out); end
        checks++; if (activation_out !== 9'h000) begin errors++; $display("FAIL reset_data: got %h want 000", activation_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_out); end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow_out); end
        checks++; if (psum_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", psum_ready_out); end
        @(negedge clk_in); rst_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_packing();
        cfg_passes_in = 4'd1; cfg_threshold_in = 16'sd0;
        send_pattern(8, 1'b0);
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL pack_early_valid: got %b want 0", act_valid_out); end
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL pack_busy: got %b want 1", busy_out); end
        send_beat(pat_a[8]);
        checks++; if (act_valid_out !== 1'b1) begin errors++; $display("FAIL pack_valid: got %b want 1", act_valid_out); end
        checks++; if (activation_out !== 9'h0B5) begin errors++; $display("FAIL pack_word: got %h want 0b5", activation_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL pack_idle: got %b want 0", busy_out); end
        pop_word();
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL pack_popped: got %b want 0", act_valid_out); end
    endtask

    task automatic test_multipass();
        cfg_passes_in = 4'd3; cfg_threshold_in = 16'sd5;
        send_beat(3);
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL mp_busy1: got %b want 1", busy_out); end
        send_beat(3);
        checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL mp_busy2: got %b want 1", busy_out); end
        send_beat(-1);
        send_beat(3); send_beat(3); send_beat(-2);
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL mp_no_word: got %b want 0", act_valid_out); end
        send_flush();
        checks++; if (activation_out !== 9'h001 || act_valid_out !== 1'b1) begin errors++; $display("FAIL mp_word: got %b/%h want 1/001", act_valid_out, activation_out); end
        pop_word();
    endtask

    task automatic test_saturation();
        cfg_passes_in = 4'd15; cfg_threshold_in = 16'sd32767;
        for (int i = 0; i < 15; i++) send_beat(8191);
        send_flush();
        checks++; if (activation_out !== 9'h001 || act_valid_out !== 1'b1) begin errors++; $display("FAIL sat_pos: got %b/%h want 1/001", act_valid_out, activation_out); end
        pop_word();
        cfg_threshold_in = 16'h8000;
        for (int i = 0; i < 15; i++) send_beat(-8192);
        send_flush();
        checks++; if (activation_out !== 9'h001 || act_valid_out !== 1'b1) begin errors++; $display("FAIL sat_neg: got %b/%h want 1/001", act_valid_out, activation_out); end
        pop_word();
    endtask

    task automatic test_backpressure();
        cfg_passes_in = 4'd1; cfg_threshold_in = 16'sd0; act_ready_in = 1'b0;
        send_pattern(9, 1'b0);
        send_pattern(9, 1'b1);
        checks++; if (psum_ready_out !== 1'b0) begin errors++; $display("FAIL bp_ready_low: got %b want 0", psum_ready_out); end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL bp_no_overflow: got %b want 0", overflow_out); end
        send_beat(5);
        checks++; if (overflow_out !== 1'b1) begin errors++; $display("FAIL bp_overflow: got %b want 1", overflow_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL bp_drop_busy: got %b want 0", busy_out); end
        checks++; if (activation_out !== 9'h0B5) begin errors++; $display("FAIL bp_head0: got %h want 0b5", activation_out); end
        pop_word();
        checks++; if (psum_ready_out !== 1'b1) begin errors++; $display("FAIL bp_ready_high: got %b want 1", psum_ready_out); end
        checks++; if (activation_out !== 9'h15A || act_valid_out !== 1'b1) begin errors++; $display("FAIL bp_head1: got %b/%h want 1/15a", act_valid_out, activation_out); end
        pop_word();
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", act_valid_out); end
    endtask

    task automatic test_flush();
        cfg_passes_in = 4'd1; cfg_threshold_in = 16'sd0;
        for (int i = 0; i < 4; i++) send_beat(i + 1);
        send_flush();
        checks++; if (activation_out !== 9'h00F || act_valid_out !== 1'b1) begin errors++; $display("FAIL flush_word: got %b/%h want 1/00f", act_valid_out, activation_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", busy_out); end
        pop_word();
        send_flush();
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL flush_empty: got %b want 0", act_valid_out); end
        // Flush together with the word-completing beat yields one word only.
        send_pattern(8, 1'b1);
        flush_in = 1'b1;
        send_beat(pat_b[8]);
        flush_in = 1'b0;
        checks++; if (activation_out !== 9'h15A || act_valid_out !== 1'b1) begin errors++; $display("FAIL flush_coincide: got %b/%h want 1/15a", act_valid_out, activation_out); end
        pop_word();
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL flush_single: got %b want 0", act_valid_out); end
    endtask

    task automatic test_back_to_back();
        cfg_passes_in = 4'd1; cfg_threshold_in = 16'sd0; act_ready_in = 1'b0;
        send_pattern(9, 1'b0);
        send_pattern(8, 1'b1);
        // Push of the second word and pop of the first on the same edge.
        act_ready_in = 1'b1;
        send_beat(pat_b[8]);
        act_ready_in = 1'b0;
        checks++; if (activation_out !== 9'h15A || act_valid_out !== 1'b1) begin errors++; $display("FAIL b2b_head: got %b/%h want 1/15a", act_valid_out, activation_out); end
        checks++; if (psum_ready_out !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", psum_ready_out); end
        // With ready held high, an empty buffer must not bypass the push.
        act_ready_in = 1'b1;
        send_pattern(9, 1'b0);
        checks++; if (activation_out !== 9'h0B5 || act_valid_out !== 1'b1) begin errors++; $display("FAIL b2b_nobypass: got %b/%h want 1/0b5", act_valid_out, activation_out); end
        @(posedge clk_in); #1;
        act_ready_in = 1'b0;
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b want 0", act_valid_out); end
    endtask

    task automatic test_reset_mid();
        cfg_passes_in = 4'd1; cfg_threshold_in = 16'sd0; act_ready_in = 1'b0;
        send_beat(8000); // dropped-free filler keeps overflow state from before
        send_pattern(8, 1'b0);
        send_pattern(5, 1'b1);
        @(negedge clk_in); rst_in = 1'b0;
        #1;
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", act_valid_out); end
        checks++; if (activation_out !== 9'h000) begin errors++; $display("FAIL rm_data: got %h want 000", activation_out); end
        checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", busy_out); end
        checks++; if (overflow_out !== 1'b0) begin errors++; $display("FAIL rm_overflow: got %b want 0", overflow_out); end
        checks++; if (psum_ready_out !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b want 1", psum_ready_out); end
        @(negedge clk_in); rst_in = 1'b1;
        @(posedge clk_in); #1;
        send_pattern(9, 1'b1);
        checks++; if (activation_out !== 9'h15A || act_valid_out !== 1'b1) begin errors++; $display("FAIL rm_fresh: got %b/%h want 1/15a", act_valid_out, activation_out); end
        pop_word();
        checks++; if (act_valid_out !== 1'b0) begin errors++; $display("FAIL rm_drained: got %b want 0", act_valid_out); end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_packing();
        test_multipass();
        test_saturation();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
